mod_reduce_seq: RTL and testbench



---
 rtl/mod_reduce_seq.sv | 114 +++++++++++
 tb/tb_mod_reduce_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_reduce_seq.sv
// ---------------------------------------------------------------------------
// mod_reduce_seq : sequential operand mod MOD via per-cycle Horner digit steps
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mod_reduce_seq #(
  parameter int MOD   = 4051,
  parameter int W     = 12,
  parameter int IN_W  = 500,
  parameter int CHUNK = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            busy
);

  localparam int NCH = (IN_W + CHUNK - 1) / CHUNK;
  localparam int SRW = NCH * CHUNK;
  localparam int CW  = $clog2(NCH) + 1;
  localparam int TW  = W + CHUNK;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SRW-1:0]  sr;
  logic [W-1:0]    acc;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   t_red;
  logic [W-1:0]    acc_nxt;

  // acc < MOD keeps t below MOD<<CHUNK, so the descending subtract chain fully reduces it
  always_comb begin
    t_red = {acc, sr[SRW-1 -: CHUNK]};
    for (int k = CHUNK; k >= 0; k--) begin
      if (t_red >= (TW'(MOD) << k)) begin
        t_red = t_red - (TW'(MOD) << k);
      end
    end
    acc_nxt = t_red[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sr  <= SRW'(in_data);
            acc <= '0;
            cnt <= '0;
          end
        end
        S_RUN: begin
          sr  <= sr << CHUNK;
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) out_data <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mod_reduce_seq.sv
// Scoreboard bench for mod_reduce_seq: default instance plus a MOD=7 instance.
`default_nettype none

module tb_mod_reduce_seq;

  localparam int MOD  = 4051;
  localparam int W    = 12;
  localparam int IN_W = 500;
  localparam int NCH  = 84;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_data;
  logic            busy;

  logic            s_in_valid = 1'b0;
  logic            s_in_ready;
  logic [11:0]     s_in_data = '0;
  logic            s_out_valid;
  logic            s_out_ready = 1'b1;
  logic [2:0]      s_out_data;
  logic            s_busy;

  mod_reduce_seq #(.MOD(MOD), .W(W), .IN_W(IN_W), .CHUNK(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  mod_reduce_seq #(.MOD(7), .W(3), .IN_W(12), .CHUNK(3)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .busy(s_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_q[$];
  int acc_cyc_q[$];
  bit rand_ready = 1'b0;
  bit prev_ov = 1'b0;
  bit prev_or = 1'b0;
  logic [W-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bit-serial long division remainder: independent of the chunked datapath.
  function automatic int ref_mod(input logic [IN_W-1:0] x, input int m);
    longint r = 0;
    for (int i = IN_W - 1; i >= 0; i--) r = (r * 2 + longint'(x[i])) % m;
    return int'(r);
  endfunction

  function automatic logic [IN_W-1:0] rand_op();
    logic [IN_W-1:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[IN_W-33:0], 32'($urandom)};
    case ($urandom_range(0, 3))
      0: v = v >> $urandom_range(0, IN_W - 1);
      1: v = IN_W'($urandom_range(0, 9000));
      2: v = '1;
      default: ;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: records accepts, checks latency, stability and residues on handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_cyc_q.delete();
      prev_ov = 1'b0;
      prev_or = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mod(in_data, MOD));
        acc_cyc_q.push_back(cyc + 1);
      end
      if (prev_ov && !prev_or) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && !prev_ov) begin
        if (acc_cyc_q.size() == 0) check("unexpected_valid", out_valid, 0);
        else check("latency", cyc - acc_cyc_q.pop_front(), NCH);
      end
      if (out_valid) check("range", out_data < W'(MOD), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_data, 0);
        else check("residue", out_data, exp_q.pop_front());
      end
      prev_ov = out_valid;
      prev_or = out_ready;
      prev_data = out_data;
    end
  end

  task automatic send(input logic [IN_W-1:0] d);
    int n = 0;
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    while (!ok && n < 2000) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    check("accept", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = rand_op();
  endtask

  task automatic run_directed(input logic [IN_W-1:0] d, input int expv);
    int n = 0;
    send(d);
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("directed_valid", out_valid, 1);
    check("directed_value", out_data, expv);
  endtask

  task automatic small_run(input logic [11:0] d, input int expv);
    int n = 0;
    @(posedge clk); #1;
    s_in_valid = 1'b1;
    s_in_data  = d;
    @(negedge clk);
    check("s_in_ready", s_in_ready, 1);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    s_in_data  = 12'h5A5;
    while (n < 50) begin
      @(posedge clk); n++; #1;
      if (s_out_valid) break;
    end
    check("s_latency", n, 4);
    check("s_value", s_out_data, expv);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [IN_W-1:0] one = '0;
    one[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);

    out_ready = 1'b1;
    run_directed('0, 0);
    run_directed(IN_W'(4051), 0);
    run_directed(IN_W'(4050), 4050);
    run_directed(IN_W'(4096), 45);
    run_directed(one << 24, 2025);
    run_directed(one << 36, 2003);
    drain();

    // Backpressure, with a new operand offered while DONE
    @(posedge clk); #1 out_ready = 1'b0;
    run_directed(IN_W'(4096), 45);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = IN_W'(7);
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_data", out_data, 45);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid, 1);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_in_ready_after", in_ready, 1);
    check("bp_valid_after", out_valid, 0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Abort mid-run
    send(one << 36);
    repeat (39) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    run_directed(IN_W'(4096), 45);
    drain();

    small_run(12'hFFF, 0);
    small_run(12'h00A, 3);

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(rand_op());
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
